xc_aesmix_seq: RTL and testbench

Request-side sequencer for the xc_aesmix functional-unit interface. It accepts a full 128-bit AES state and a direction flag. It then issues one MixColumns/InvMixColumns request per column to an attached xc_aesmix unit (FAST or area-optimised), using the unit's valid/ready/flush protocol, and returns the assembled 128-bit result. It sits between the round controller and the mix unit, and keeps that unit's input-stability rules on the unit's behalf.

---
 rtl/xc_aesmix_seq.sv | 121 ++++++++++++
 tb/tb_xc_aesmix_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_aesmix_seq.sv
// Request-side sequencer for an xc_aesmix unit: splits a 128-bit AES state into
// four column requests, drives the valid/ready/flush protocol, reassembles the result.
module xc_aesmix_seq #(
  parameter logic [15:0] FILL = 16'h0000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_enc,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         fu_valid,
  output logic [31:0]  fu_rs1,
  output logic [31:0]  fu_rs2,
  output logic         fu_enc,
  input  logic         fu_ready,
  input  logic [31:0]  fu_result,
  output logic         fu_flush,
  output logic [31:0]  fu_flush_data,
  input  logic [31:0]  flush_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       col;
  logic             abort_pend;
  logic [3:0][31:0] res_buf;
  logic [3:0][31:0] cap_state;
  logic             cap_enc;
  logic [31:0]      cur_col;
  logic             fire;
  logic             stop;

  assign fire    = fu_valid && fu_ready;
  assign stop    = abort_pend || abort;
  assign cur_col = cap_state[col];

  // Request fields are driven straight from registers so they hold while stalled.
  assign in_ready      = (state == IDLE);
  assign fu_valid      = (state == ISSUE);
  assign out_valid     = (state == DONE);
  assign fu_rs1        = fu_valid ? {FILL, cur_col[15:0]} : 32'h0;
  assign fu_rs2        = fu_valid ? {cur_col[31:16], FILL} : 32'h0;
  assign fu_enc        = fu_valid && cap_enc;
  assign fu_flush      = fire;
  assign fu_flush_data = flush_data;
  assign out_state     = out_valid ? res_buf : 128'h0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ISSUE;
      ISSUE: begin
        if (fire) begin
          if (stop)           state_nxt = IDLE;
          else if (col == 2'd3) state_nxt = DONE;
        end
      end
      DONE:    if (out_ready || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col        <= 2'd0;
      abort_pend <= 1'b0;
      res_buf    <= '0;
      cap_state  <= '0;
      cap_enc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_state  <= in_state;
            cap_enc    <= in_enc;
            col        <= 2'd0;
            abort_pend <= 1'b0;
          end
        end
        ISSUE: begin
          if (fire) begin
            if (stop) begin
              // Aborted operation leaves no key-dependent data behind.
              res_buf    <= '0;
              cap_state  <= '0;
              cap_enc    <= 1'b0;
              abort_pend <= 1'b0;
              col        <= 2'd0;
            end else begin
              res_buf[col] <= fu_result;
              if (col != 2'd3) col <= col + 2'd1;
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready || abort) begin
            res_buf   <= '0;
            cap_state <= '0;
            cap_enc   <= 1'b0;
            col       <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_aesmix_seq.sv
// Directed bench for xc_aesmix_seq with a behavioural MixColumns unit of
// configurable latency and optional random ready gaps.
module tb_xc_aesmix_seq;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_enc, abort;
  logic [127:0] in_state, out_state;
  logic         out_valid, out_ready;
  logic         fu_valid, fu_enc, fu_ready, fu_flush;
  logic [31:0]  fu_rs1, fu_rs2, fu_result, fu_flush_data, flush_data;

  int checks = 0;
  int errors = 0;

  // FU model controls
  int   lat_base = 0;
  logic rnd_en   = 1'b0;
  logic hold     = 1'b0;
  int   wcnt     = 0;
  int   extra    = 0;

  // Monitor counters
  int   flush_cnt  = 0;
  int   stab_viol  = 0;
  int   fdata_viol = 0;
  logic p_stall = 1'b0, p_rst = 1'b1, p_enc = 1'b0;
  logic [31:0] p_rs1 = '0, p_rs2 = '0;

  xc_aesmix_seq #(.FILL(16'h0000)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_enc(in_enc),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .fu_valid(fu_valid), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_enc(fu_enc),
    .fu_ready(fu_ready), .fu_result(fu_result),
    .fu_flush(fu_flush), .fu_flush_data(fu_flush_data), .flush_data(flush_data)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] c, input logic enc);
    logic [7:0] a [4];
    logic [7:0] m [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = c[8*i +: 8];
    if (enc) begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    else     begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    r = '0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = gmul(a[i], m[0]) ^ gmul(a[(i+1)%4], m[1]) ^
                    gmul(a[(i+2)%4], m[2]) ^ gmul(a[(i+3)%4], m[3]);
    return r;
  endfunction

  assign fu_result = mix({fu_rs2[31:16], fu_rs1[15:0]}, fu_enc);
  assign fu_ready  = fu_valid && !hold && (wcnt >= lat_base + extra);

  always @(posedge clock) begin
    if (fu_flush) begin
      wcnt  <= 0;
      extra <= rnd_en ? int'($urandom_range(0, 2)) : 0;
    end else if (fu_valid) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt  <= 0;
      extra <= 0;
    end
  end

  always @(negedge clock) begin
    if (p_stall && !p_rst &&
        (!fu_valid || fu_rs1 != p_rs1 || fu_rs2 != p_rs2 || fu_enc != p_enc))
      stab_viol <= stab_viol + 1;
    if (fu_flush) begin
      flush_cnt <= flush_cnt + 1;
      if (fu_flush_data != flush_data) fdata_viol <= fdata_viol + 1;
    end
    p_stall <= fu_valid && !fu_ready;
    p_rst   <= reset;
    p_rs1   <= fu_rs1;
    p_rs2   <= fu_rs2;
    p_enc   <= fu_enc;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic run_op(input logic [127:0] st, input logic en, input int lat, input logic rnd,
                        input logic [127:0] exp, input int exp_cyc, input logic do_rel);
    int k, f0, s0;
    lat_base = lat; rnd_en = rnd;
    flush_data = $urandom;
    f0 = flush_cnt; s0 = stab_viol + fdata_viol;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_state = st; in_enc = en;
    step();
    in_valid = 1'b0; in_state = '0; in_enc = 1'b0;
    chk("fu_rs1_col0", fu_rs1, {16'h0, st[15:0]});
    chk("fu_rs2_col0", fu_rs2, {st[31:16], 16'h0});
    chk("fu_enc", fu_enc, en);
    k = 1;
    while (!out_valid && k < 300) begin step(); k++; end
    chk("out_valid_rise", out_valid, 1);
    if (exp_cyc != 0) chk("latency", k, exp_cyc);
    chk("out_state", out_state, exp);
    chk("flush_pulses", flush_cnt - f0, 4);
    chk("fu_stable_and_flush_data", stab_viol + fdata_viol, s0);
    if (do_rel) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("idle_after_out", in_ready, 1);
      chk("out_valid_drop", out_valid, 0);
      chk("out_state_zero", out_state, 0);
    end
  endtask

  typedef struct {
    logic [127:0] st;
    logic         enc;
    int           lat;
    logic         rnd;
    logic [127:0] exp;
    int           cyc;
  } vec_t;

  localparam logic [127:0] S1 = 128'h01010101_c6c6c6c6_5c220af2_455313db;
  localparam logic [127:0] E1 = 128'h01010101_c6c6c6c6_9d58dc9f_bca14d8e;
  localparam logic [127:0] S3 = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
  localparam logic [127:0] E3 = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;

  vec_t tbl [5];

  initial begin
    int f0, k;
    tbl[0] = '{S1, 1'b1, 0, 1'b0, E1, 5};
    tbl[1] = '{E1, 1'b0, 0, 1'b0, S1, 5};
    tbl[2] = '{S1, 1'b1, 2, 1'b1, E1, 0};
    tbl[3] = '{S3, 1'b1, 1, 1'b0, E3, 9};
    tbl[4] = '{E3, 1'b0, 3, 1'b0, S3, 17};

    reset = 1'b1; in_valid = 1'b0; in_state = '0; in_enc = 1'b0; abort = 1'b0;
    out_ready = 1'b0; flush_data = 32'h0;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_fu_flush", fu_flush, 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_fu_fields", {fu_rs1, fu_rs2, fu_enc}, 0);

    for (int i = 0; i < 5; i++)
      run_op(tbl[i].st, tbl[i].enc, tbl[i].lat, tbl[i].rnd, tbl[i].exp, tbl[i].cyc, 1'b1);

    // Output backpressure with an ignored in_valid pulse
    run_op(S1, 1'b1, 0, 1'b0, E1, 5, 1'b0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3); in_state = S3; in_enc = 1'b1;
      if (out_valid && !in_ready && out_state == E1 && !fu_valid) k++;
      step();
    end
    in_valid = 1'b0; in_state = '0;
    chk("backpressure_hold", k, 10);
    chk("still_done", out_state, E1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_zero", out_state, 0);
    step();
    chk("bp_pulse_ignored", fu_valid, 0);

    // Abort while stalled on column 1
    lat_base = 0; rnd_en = 1'b0;
    in_valid = 1'b1; in_state = S1; in_enc = 1'b1;
    step();
    in_valid = 1'b0; in_state = '0;
    step();
    hold = 1'b1;
    f0 = flush_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (fu_valid && fu_rs1 == {16'h0, S1[47:32]} && !out_valid) k++;
      step();
    end
    chk("abort_stall_held", k, 3);
    hold = 1'b0;
    step();
    chk("abort_flush_one", flush_cnt - f0, 1);
    chk("abort_idle", in_ready, 1);
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid || fu_valid) k++;
      step();
    end
    chk("abort_no_more", k, 0);
    run_op(S1, 1'b1, 0, 1'b0, E1, 5, 1'b1);

    // Reset while issuing column 2
    in_valid = 1'b1; in_state = S3; in_enc = 1'b1;
    step();
    in_valid = 1'b0; in_state = '0;
    step(); step();
    chk("col2_issue", fu_rs1, {16'h0, S3[79:64]});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_issue_fu_valid", fu_valid, 0);
    chk("rst_issue_out", {out_valid, out_state}, 0);
    chk("rst_issue_in_ready", in_ready, 1);
    run_op(S3, 1'b1, 0, 1'b0, E3, 5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
